// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, S-box table and word helpers
// Purpose: state encoding for the key schedule FSM, round-constant constants,
//          the forward S-box table, and the xtime / rot_word / sub_word helpers.
// Ports:   none (package).
package aes_pkg;

   typedef enum logic {
      KS_IDLE = 1'b0,
      KS_RUN  = 1'b1
   } ks_state_e;

   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_POLY = 8'h1b;

   // Element 0 sits in the MSBs, so SBOX[b] is the substitution of byte b.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational 8-bit AES forward S-box
// Purpose: single byte substitution, shared by the key schedule and cipher rounds.
// Ports:   in_byte  - byte to substitute
//          out_byte - substituted byte
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - sequential AES-128/192/256 key expansion, one word per clock
// Purpose: expands key_in into NW 32-bit words held in a register array and
//          serves one registered 128-bit round key per clock.
// Ports:   clk, rst         - clock, synchronous active-high reset
//          start, key_in    - load key and begin expansion (ignored while busy)
//          busy, done       - expansion running / one-cycle completion pulse
//          keys_valid       - schedule complete and stable
//          rk_idx, rk_out   - round-key index and registered round key (0 if rk_idx > NR)
//          keys_flat        - {w[0]..w[NW-1]}, only with AES_KS_FLAT_OUT_EN defined
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KEY_BITS-1:0]   key_in,
   output logic                  busy,
   output logic                  done,
   output logic                  keys_valid,
   input  logic [3:0]            rk_idx,
   output logic [127:0]          rk_out
`ifdef AES_KS_FLAT_OUT_EN
   ,
   output logic [32*(4*(KEY_BITS/32+7))-1:0] keys_flat
`endif
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);

   ks_state_e     state_q, state_d;
   logic [5:0]    i_q, i_d;
   logic [2:0]    j_q, j_d;
   logic [7:0]    rcon_q, rcon_d;
   logic          keys_valid_q, keys_valid_d;
   logic          done_q, done_d;
   logic [127:0]  rk_out_q, rk_out_d;
   logic [31:0]   w_q [NW];
   logic [31:0]   w_d [NW];

   logic [31:0]   prev_word, old_word, temp;
   logic [31:0]   sbox_in, sbox_out;
   logic [5:0]    rk_base;

   // SubWord is four byte S-boxes; RotWord is folded in ahead of them only
   // on j==0, so there is a single S-box pass per cycle.
   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (sbox_in[8*b +: 8]),
         .out_byte (sbox_out[8*b +: 8])
      );
   end

   always_comb begin
      prev_word = w_q[i_q - 6'd1];
      old_word  = w_q[i_q - 6'(NK)];
      sbox_in   = (j_q == 3'd0) ? rot_word(prev_word) : prev_word;
      if (j_q == 3'd0) begin
         temp = sbox_out ^ {rcon_q, 24'h0};
      end else if (NK == 8 && j_q == 3'd4) begin
         temp = sbox_out;
      end else begin
         temp = prev_word;
      end
   end

   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      j_d          = j_q;
      rcon_d       = rcon_q;
      keys_valid_d = keys_valid_q;
      done_d       = 1'b0;
      w_d          = w_q;

      rk_base  = {rk_idx, 2'b00};
      rk_out_d = '0;
      if (rk_idx <= 4'(NR)) begin
         rk_out_d = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
      end

      case (state_q)
         KS_IDLE: begin
            if (start) begin
               for (int k = 0; k < NK; k++) begin
                  w_d[k] = key_in[KEY_BITS-1-32*k -: 32];
               end
               i_d          = 6'(NK);
               j_d          = 3'd0;
               rcon_d       = RCON_INIT;
               keys_valid_d = 1'b0;
               state_d      = KS_RUN;
            end
         end
         KS_RUN: begin
            w_d[i_q] = old_word ^ temp;
            if (j_q == 3'd0) begin
               rcon_d = xtime(rcon_q);
            end
            j_d = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
            i_d = i_q + 6'd1;
            if (i_q == 6'(NW - 1)) begin
               state_d      = KS_IDLE;
               done_d       = 1'b1;
               keys_valid_d = 1'b1;
            end
         end
         default: state_d = KS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= KS_IDLE;
         i_q          <= '0;
         j_q          <= '0;
         rcon_q       <= RCON_INIT;
         keys_valid_q <= 1'b0;
         done_q       <= 1'b0;
         rk_out_q     <= '0;
         for (int k = 0; k < NW; k++) begin
            w_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         j_q          <= j_d;
         rcon_q       <= rcon_d;
         keys_valid_q <= keys_valid_d;
         done_q       <= done_d;
         rk_out_q     <= rk_out_d;
         w_q          <= w_d;
      end
   end

   assign busy       = (state_q == KS_RUN);
   assign done       = done_q;
   assign keys_valid = keys_valid_q;
   assign rk_out     = rk_out_q;

`ifdef AES_KS_FLAT_OUT_EN
   always_comb begin
      for (int k = 0; k < NW; k++) begin
         keys_flat[32*(NW-1-k) +: 32] = w_q[k];
      end
   end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed known-answer bench for aes_key_schedule (128/192/256)
module tb_aes_key_schedule;

   localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_TEAM = 128'h5468617473206d79204b756e67204675;
   localparam logic [191:0] KEY_192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] KEY_256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] TEAM_RK1  = 128'he232fcf191129188b159e4e6d679a293;
   localparam logic [127:0] TEAM_RK10 = 128'h28fddef86da4244accc0a4fe3b316f26;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          s128, s192, s256;
   logic [127:0]  key128;
   logic [191:0]  key192;
   logic [255:0]  key256;
   logic          busy128, busy192, busy256;
   logic          done128, done192, done256;
   logic          kv128, kv192, kv256;
   logic [3:0]    idx128, idx192, idx256;
   logic [127:0]  rk128, rk192, rk256;
`ifdef AES_KS_FLAT_OUT_EN
   logic [1407:0] flat128;
   logic [1663:0] flat192;
   logic [1919:0] flat256;
`endif

   aes_key_schedule #(.KEY_BITS(128)) dut128 (
      .clk(clk), .rst(rst), .start(s128), .key_in(key128), .busy(busy128), .done(done128),
      .keys_valid(kv128), .rk_idx(idx128), .rk_out(rk128)
`ifdef AES_KS_FLAT_OUT_EN
      , .keys_flat(flat128)
`endif
   );
   aes_key_schedule #(.KEY_BITS(192)) dut192 (
      .clk(clk), .rst(rst), .start(s192), .key_in(key192), .busy(busy192), .done(done192),
      .keys_valid(kv192), .rk_idx(idx192), .rk_out(rk192)
`ifdef AES_KS_FLAT_OUT_EN
      , .keys_flat(flat192)
`endif
   );
   aes_key_schedule #(.KEY_BITS(256)) dut256 (
      .clk(clk), .rst(rst), .start(s256), .key_in(key256), .busy(busy256), .done(done256),
      .keys_valid(kv256), .rk_idx(idx256), .rk_out(rk256)
`ifdef AES_KS_FLAT_OUT_EN
      , .keys_flat(flat256)
`endif
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int           sel;
      logic [3:0]   idx;
      logic [127:0] exp;
   } vec_t;
   vec_t vecs [17];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic done_of(input int sel);
      case (sel)
         0:       return done128;
         1:       return done192;
         default: return done256;
      endcase
   endfunction

   task automatic rd(input int sel, input logic [3:0] idx, output logic [127:0] val);
      case (sel)
         0:       idx128 = idx;
         1:       idx192 = idx;
         default: idx256 = idx;
      endcase
      step();
      case (sel)
         0:       val = rk128;
         1:       val = rk192;
         default: val = rk256;
      endcase
   endtask

   task automatic wait_done(input int sel, output int cyc);
      cyc = 0;
      while (!done_of(sel) && cyc < 200) begin
         step();
         cyc++;
      end
   endtask

   initial begin
      logic [127:0] v;
      int c, c128, c192, c256;

      vecs[0]  = '{0, 4'd0,  KEY_A1};
      vecs[1]  = '{0, 4'd1,  A1_RK1};
      vecs[2]  = '{0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      vecs[3]  = '{0, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
      vecs[4]  = '{0, 4'd10, A1_RK10};
      vecs[5]  = '{0, 4'd11, 128'h0};
      vecs[6]  = '{0, 4'd15, 128'h0};
      vecs[7]  = '{1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
      vecs[8]  = '{1, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
      vecs[9]  = '{1, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
      vecs[10] = '{1, 4'd13, 128'h0};
      vecs[11] = '{2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
      vecs[12] = '{2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
      vecs[13] = '{2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
      vecs[14] = '{2, 4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a};
      vecs[15] = '{2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
      vecs[16] = '{2, 4'd15, 128'h0};

      rst = 1'b1;
      s128 = 1'b0; s192 = 1'b0; s256 = 1'b0;
      key128 = '0; key192 = '0; key256 = '0;
      idx128 = '0; idx192 = '0; idx256 = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("reset_busy128", 128'(busy128), 128'h0);
      chk("reset_done128", 128'(done128), 128'h0);
      chk("reset_kv128",   128'(kv128),   128'h0);
      chk("reset_rk128",   rk128,         128'h0);
      chk("reset_kv192",   128'(kv192),   128'h0);
      chk("reset_kv256",   128'(kv256),   128'h0);

      // All three key sizes start on the same edge; measure done latency.
      key128 = KEY_A1; key192 = KEY_192; key256 = KEY_256;
      s128 = 1'b1; s192 = 1'b1; s256 = 1'b1;
      step();
      s128 = 1'b0; s192 = 1'b0; s256 = 1'b0;
      chk("start_busy128", 128'(busy128), 128'h1);
      c128 = -1; c192 = -1; c256 = -1;
      for (int n = 1; n <= 100; n++) begin
         step();
         if (done128 && c128 < 0) c128 = n;
         if (done192 && c192 < 0) c192 = n;
         if (done256 && c256 < 0) c256 = n;
      end
      chk("latency128", 128'(c128), 128'd40);
      chk("latency192", 128'(c192), 128'd46);
      chk("latency256", 128'(c256), 128'd52);
      chk("final_kv128",   128'(kv128),   128'h1);
      chk("final_kv192",   128'(kv192),   128'h1);
      chk("final_kv256",   128'(kv256),   128'h1);
      chk("final_busy256", 128'(busy256), 128'h0);
      chk("final_done128", 128'(done128), 128'h0);

      for (int k = 0; k < 17; k++) begin
         rd(vecs[k].sel, vecs[k].idx, v);
         chk($sformatf("vec%0d_sel%0d_rk%0d", k, vecs[k].sel, vecs[k].idx), v, vecs[k].exp);
      end

      // Restart from a valid schedule, then a start 5 cycles into RUN with another key.
      key128 = KEY_A1;
      s128 = 1'b1;
      step();
      s128 = 1'b0;
      chk("restart_kv_drop", 128'(kv128),   128'h0);
      chk("restart_busy",    128'(busy128), 128'h1);
      repeat (4) step();
      key128 = KEY_TEAM;
      s128 = 1'b1;
      step();
      s128 = 1'b0;
      wait_done(0, c);
      chk("ignored_start_latency", 128'(c), 128'd35);
      rd(0, 4'd10, v);
      chk("ignored_start_rk10", v, A1_RK10);
      rd(0, 4'd1, v);
      chk("ignored_start_rk1", v, A1_RK1);

      // Reset at cycle 20 of an expansion, then a fresh expansion.
      idx128 = 4'd1;
      key128 = KEY_A1;
      s128 = 1'b1;
      step();
      s128 = 1'b0;
      repeat (19) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", 128'(busy128), 128'h0);
      chk("midrst_kv",   128'(kv128),   128'h0);
      chk("midrst_done", 128'(done128), 128'h0);
      chk("midrst_rk",   rk128,         128'h0);
      chk("midrst_kv192", 128'(kv192),  128'h0);
      rd(0, 4'd0, v);
      chk("midrst_w_cleared", v, 128'h0);

      key128 = KEY_TEAM;
      s128 = 1'b1;
      step();
      s128 = 1'b0;
      wait_done(0, c);
      chk("team_latency", 128'(c), 128'd40);
      rd(0, 4'd10, v);
      chk("team_rk10", v, TEAM_RK10);
      rd(0, 4'd1, v);
      chk("team_rk1", v, TEAM_RK1);
`ifdef AES_KS_FLAT_OUT_EN
      chk("team_flat_hi", flat128[1407 -: 128], KEY_TEAM);
      chk("team_flat_lo", flat128[127:0],       TEAM_RK10);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential, parametrised AES key expansion engine for the AES core. It takes a 128/192/256-bit cipher key, generates the full round-key schedule one 32-bit word per clock, and holds the schedule in an internal word array. The cipher datapath reads it one 128-bit round key at a time. It supersedes the combinational AES-128-only expander: less logic per cycle, multiple key sizes, and a start/done handshake.

## Interface
- `KEY_BITS`, default 128: cipher key size; legal values are 128, 192 and 256. Derived values:
  - NK = KEY_BITS/32
  - NR = NK+6
  - NW = 4*(NR+1), which is 44, 52 or 60.
- `clk` input, 1 bit: the single clock. One clock; reset is synchronous and active-high.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: load `key_in` and begin expansion. Accepted only when `busy`=0.
- `key_in` input, KEY_BITS: cipher key. The MSB is the first key byte; w[0] = key_in[KEY_BITS-1 -: 32].
- `busy` output, 1 bit: expansion in progress.
- `done` output, 1 bit: one-cycle pulse when the last word has been written.
- `keys_valid` output, 1 bit: the schedule is complete and stable.
- `rk_idx` input, 4 bits: round-key index, 0..NR.
- `rk_out` output, 128 bits: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs. Registered.

## Operation
- **States:** IDLE and RUN.
- **IDLE with `start`=1:**
  - Write w[0..NK-1] from `key_in`.
  - Set i=NK, j=0 (j = i mod NK), rcon=8'h01.
  - Clear `keys_valid`, set `busy`, go to RUN.
- **RUN, every cycle:** write w[i] = w[i-NK] ^ temp, where temp depends on j:
  - j==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon = xtime(rcon), i.e. shift left and XOR 8'h1b on carry-out.
  - NK==8 and j==4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
  - Then i++ and j wraps NK-1 -> 0. Implement j as a counter; no divider.
- **RUN completion:** when i==NW-1 is written, set `busy`=0, `done`=1 for one cycle, `keys_valid`=1, and return to IDLE.
- **`start` while busy:** ignored; the current expansion continues.
- **Restart:** `start` in IDLE with `keys_valid`=1 begins a new expansion and drops `keys_valid` at the same edge.
- **Read port:** each clock, rk_out <= round key `rk_idx`.
  - `rk_idx` > NR returns 128'h0.
  - Reads while busy return the current partial array contents. The consumer must gate on `keys_valid`.
- **Reset:** `rst`=1 at any time, including mid-expansion, forces:
  - IDLE; `busy`=0, `done`=0, `keys_valid`=0
  - `rk_out`=0; all w[] = 0; rcon=8'h01.

## Timing
- `start` is sampled at edge T. w[NK..NW-1] are written at edges T+1..T+NW-NK.
- `done` is high during the cycle after edge T+NW-NK:
  - AES-128: 40 cycles after the start edge.
  - AES-192: 46 cycles.
  - AES-256: 52 cycles.
- `busy` is high from edge T until edge T+NW-NK.
- Read latency is 1 cycle: `rk_idx` is applied at edge E and `rk_out` is valid after E.
- Critical path: one w[] read mux, then S-box, then XOR. There is one S-box pass per cycle.

## Configuration
- **`AES_KS_FLAT_OUT_EN` defined:** adds output `keys_flat` [32*NW-1:0] = {w[0], w[1], …, w[NW-1]}, with w[0] in the MSBs. Its layout is bit-identical to the legacy combinational expander output (1408 bits for AES-128). It reflects the live array, and is 0 after reset.
- **Not defined:** the port is absent and only `rk_out` exposes keys.

## Structure
- Package `aes_pkg`:
  - `sbox` constant table
  - `xtime` function
  - `rot_word` and `sub_word` functions
  - constants RCON_INIT=8'h01 and RCON_POLY=8'h1b.
- Sub-module `aes_sbox`: combinational 8-bit S-box shared with the cipher rounds, 4 instances for SubWord.
- w[] is a register array of NW x 32 with a single write port and a read port for the w[i-1], w[i-NK] and round-key reads.

## Test plan
- **AES-128, FIPS-197 A.1:** KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pulse `start`.
  - `done` arrives 40 cycles later.
  - rk_idx=10 -> rk_out = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
- **AES-128, team vector:** key 5468617473206d79204b756e67204675.
  - rk_idx=10 -> 28fddef86da4244accc0a4fe3b316f26.
  - With `AES_KS_FLAT_OUT_EN`: `keys_flat` equals the legacy 1408-bit expected value.
- **AES-192:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b; `done` after 46 cycles; w[51] = 01002202, i.e. rk_idx=12, low word.
- **AES-256:** key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4; `done` after 52 cycles; w[59] = 706c631e.
- **Mid-operation events:**
  - `start` pulsed 5 cycles into RUN with a different key -> ignored; the original schedule completes unchanged.
  - `rst` at cycle 20 -> `busy`/`keys_valid`/`rk_out` are 0 next cycle, and a following `start` produces the correct schedule.
- **Out-of-range read:** rk_idx=15 -> rk_out=0.
